// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator onto a word-addressed single-ported data memory
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_i, wr_i           start an access (sampled only while ready_o=1); 1=store, 0=load
//   funct3_i              RISC-V size/sign encoding (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr_i, wdata_i       byte address and store data, registered at acceptance
//   ready_o               idle and accepting a request
//   done_o, err_o         one-cycle completion pulse; err_o qualifies it
//   rdata_o               extended load result, held until the next load completes
//   mem_we_o, mem_a_o     memory write enable and word-aligned byte address
//   mem_wd_o, mem_rd_i    memory write data; combinational read data for mem_a_o

module mem_access_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        wr_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    logic        f3_bad;
    logic        misalign;
    logic        out_of_range;
    logic        acc_err;
    logic        accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request screening, evaluated on the live inputs at acceptance.
    always_comb begin
        f3_bad       = wr_i ? (funct3_i > 3'd2)
                            : ((funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11));
        misalign     = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        out_of_range = (addr_i[31:2] >= MEM_WORDS_W);
        acc_err      = f3_bad || misalign || out_of_range;
    end

    assign accept = (state_q == S_IDLE) && req_i;

    // Little-endian lane extraction; funct3_q[2] set means zero-extend.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_rd_i[7:0];
            2'd1:    byte_sel = mem_rd_i[15:8];
            2'd2:    byte_sel = mem_rd_i[23:16];
            default: byte_sel = mem_rd_i[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
            default: load_ext = mem_rd_i;
        endcase
    end

    // Sub-word store: overlay the new lane onto the word read in RD.
    always_comb begin
        merged = merge_q;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (acc_err)                             state_d = S_DONE;
                    else if (wr_i && (funct3_i[1:0] == 2'b10)) state_d = S_WR;
                    else                                     state_d = S_RD;
                end
            end
            S_RD:    state_d = wr_q ? S_WR : S_DONE;
            S_WR:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            merge_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q     <= wr_i;
                funct3_q <= funct3_i;
                addr_q   <= addr_i;
                wdata_q  <= wdata_i;
                err_q    <= acc_err;
            end
            if (state_q == S_RD) begin
                if (wr_q) merge_q <= mem_rd_i;
                else      rdata_q <= load_ext;
            end
        end
    end

    // Memory-side outputs decode straight from the state so reset removes them at once.
    always_comb begin
        ready_o  = (state_q == S_IDLE);
        done_o   = (state_q == S_DONE);
        err_o    = (state_q == S_DONE) && err_q;
        rdata_o  = rdata_q;
        mem_we_o = (state_q == S_WR);
        mem_a_o  = 32'd0;
        mem_wd_o = 32'd0;
        if ((state_q == S_RD) || (state_q == S_WR)) begin
            mem_a_o = {addr_q[31:2], 2'b00};
        end
        if (state_q == S_WR) begin
            mem_wd_o = (funct3_q[1:0] == 2'b10) ? wdata_q : merged;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready, done, err;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic        pre_we = 1'b0;
    logic [5:0]  pre_a = 6'd0;
    logic [31:0] pre_d = 32'd0;
    logic [31:0] mem [0:63];

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wec;
        logic [31:0] wea;
        logic [31:0] wed;
        logic [31:0] aor;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .wr_i     (wr),
        .funct3_i (funct3),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .ready_o  (ready),
        .done_o   (done),
        .err_o    (err),
        .rdata_o  (rdata),
        .mem_we_o (mem_we),
        .mem_a_o  (mem_a),
        .mem_wd_o (mem_wd),
        .mem_rd_i (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (pre_we)      mem[pre_a] <= pre_d;
        else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one request, push its expectation, watch the DUT until done, then pop and compare.
    task automatic access(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                          input int e_wec, input logic [31:0] e_wea, input logic [31:0] e_wed,
                          input logic [31:0] e_aor, input logic release_rst);
        exp_t        e, got;
        int          n;
        bit          found;
        int          wec;
        logic [31:0] wea, wed, aor;
        e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.wec = e_wec;
        e.wea = e_wea; e.wed = e_wed; e.aor = e_aor;
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        check({tag, ".ready"}, 32'(ready), 32'd1);
        req = 1'b1; wr = w; funct3 = f3; addr = a; wdata = d;
        sb.push_back(e);
        n = 0; found = 1'b0; wec = 0; wea = 32'd0; wed = 32'd0; aor = 32'd0;
        got.err = 1'b0; got.rdata = 32'd0;
        while (n < 12 && !found) begin
            @(negedge clk);
            if (n == 0) begin
                // Fields must be registered; scramble the live inputs after acceptance.
                req = 1'b0; wr = ~w; funct3 = 3'd7; addr = 32'hFFFF_FFFF; wdata = 32'h0;
            end
            n++;
            aor = aor | mem_a;
            if (mem_we) begin
                wec++;
                wea = mem_a;
                wed = mem_wd;
            end
            if (done) begin
                found = 1'b1;
                got.err = err;
                got.rdata = rdata;
            end
        end
        check({tag, ".done_seen"}, 32'(found), 32'd1);
        e = sb.pop_front();
        check({tag, ".latency"}, 32'(n), 32'(e.lat));
        check({tag, ".err"}, 32'(got.err), 32'(e.err));
        check({tag, ".rdata"}, got.rdata, e.rdata);
        check({tag, ".we_cycles"}, 32'(wec), 32'(e.wec));
        check({tag, ".we_addr"}, wea, e.wea);
        check({tag, ".we_data"}, wed, e.wed);
        check({tag, ".addr_seen"}, aor, e.aor);
    endtask

    initial begin
        #2;
        check("rst.ready", 32'(ready), 32'd1);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_a", mem_a, 32'd0);
        check("rst.mem_wd", mem_wd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(6'd4, 32'h8899AABB);
        preload(6'd5, 32'h00000000);

        // loads: tag, wr, f3, addr, wdata, rdata, err, lat, wec, wea, wed, aor, rel
        access("lb_12",  1'b0, 3'd0, 32'h12, 32'h0, 32'hFFFFFF99, 1'b0, 2, 0, 32'h0, 32'h0, 32'h10, 1'b0);
        access("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 0, 32'h0, 32'h0, 32'h10, 1'b0);
        access("lh_10",  1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0, 32'h0, 32'h0, 32'h10, 1'b0);
        access("lhu_12", 1'b0, 3'd5, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0, 32'h0, 32'h0, 32'h10, 1'b0);
        access("lw_10",  1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 32'h0, 32'h0, 32'h10, 1'b0);

        // stores and read-back
        access("sb_11",  1'b1, 3'd0, 32'h11, 32'h12345677, 32'h8899AABB, 1'b0, 3, 1, 32'h10, 32'h889977BB, 32'h10, 1'b0);
        access("lw_10b", 1'b0, 3'd2, 32'h10, 32'h0, 32'h889977BB, 1'b0, 2, 0, 32'h0, 32'h0, 32'h10, 1'b0);
        access("sw_14",  1'b1, 3'd2, 32'h14, 32'hDEADBEEF, 32'h889977BB, 1'b0, 2, 1, 32'h14, 32'hDEADBEEF, 32'h14, 1'b0);
        access("sh_16",  1'b1, 3'd1, 32'h16, 32'h0000CAFE, 32'h889977BB, 1'b0, 3, 1, 32'h14, 32'hCAFEBEEF, 32'h14, 1'b0);
        access("lw_14",  1'b0, 3'd2, 32'h14, 32'h0, 32'hCAFEBEEF, 1'b0, 2, 0, 32'h0, 32'h0, 32'h14, 1'b0);

        // rejected requests: no memory activity, rdata held
        access("e_lw16", 1'b0, 3'd2, 32'h16, 32'h0, 32'hCAFEBEEF, 1'b1, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        access("e_lh11", 1'b0, 3'd1, 32'h11, 32'h0, 32'hCAFEBEEF, 1'b1, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        access("e_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, 32'hCAFEBEEF, 1'b1, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        access("e_sw100",1'b1, 3'd2, 32'h100, 32'h1, 32'hCAFEBEEF, 1'b1, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0);

        // reset while SB 0x10 sits in WR, before its write edge
        @(negedge clk);
        req = 1'b1; wr = 1'b1; funct3 = 3'd0; addr = 32'h10; wdata = 32'h00000055;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rstwr.in_wr", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rstwr.mem_we", 32'(mem_we), 32'd0);
        check("rstwr.ready", 32'(ready), 32'd1);
        check("rstwr.done", 32'(done), 32'd0);
        check("rstwr.mem_a", mem_a, 32'd0);
        check("rstwr.rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        check("rstwr.word4", mem[4], 32'h889977BB);
        access("post_rst_lw", 1'b0, 3'd2, 32'h10, 32'h0, 32'h889977BB, 1'b0, 2, 0, 32'h0, 32'h0, 32'h10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
